// File: rtl/vstore_if.sv
// Request and byte-write bundle for vstore_serializer.
// byte_mask is present only when VSTORE_BYTE_MASK_EN is defined.
interface vstore_if #(
    parameter int ADDR_W = 16,
    parameter int NBYTES = 16
);
    logic                  start;
    logic [NBYTES*8-1:0]   vec_in;
    logic [ADDR_W-1:0]     base_addr;
`ifdef VSTORE_BYTE_MASK_EN
    logic [NBYTES-1:0]     byte_mask;
`endif
    logic                  mem_ready;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [7:0]            mem_wdata;
    logic                  busy;
    logic                  done;

    // master: requester plus memory model; slave: the serializer
    modport master (
        output start, vec_in, base_addr,
`ifdef VSTORE_BYTE_MASK_EN
        output byte_mask,
`endif
        output mem_ready,
        input  mem_we, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        input  start, vec_in, base_addr,
`ifdef VSTORE_BYTE_MASK_EN
        input  byte_mask,
`endif
        input  mem_ready,
        output mem_we, mem_addr, mem_wdata, busy, done
    );
endinterface

// File: rtl/vstore_serializer.sv
// Serializes a 128-bit vector into 16 byte writes at base_addr+i, honouring mem_ready.
// Optional per-byte write mask enabled by defining VSTORE_BYTE_MASK_EN.
module vstore_serializer #(
    parameter int ADDR_W = 16,
    parameter int NBYTES = 16
) (
    input  logic    clk,
    input  logic    rst,
    vstore_if.slave bus
);
    localparam int               IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NBYTES*8-1:0]  vec_q;
    logic [ADDR_W-1:0]    base_q;
    logic [NBYTES-1:0]    mask_q;

    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic                 retire;
    logic [NBYTES-1:0]    mask_in;
    logic [NBYTES*8-1:0]  vec_sel;
    logic [ADDR_W-1:0]    base_sel;
    logic [NBYTES-1:0]    mask_sel;

`ifdef VSTORE_BYTE_MASK_EN
    assign mask_in = bus.byte_mask;
`else
    assign mask_in = '1;
`endif

    assign accept = (state_q == IDLE) && bus.start;
    // A masked-off byte (mem_we_q=0) retires unconditionally after its single cycle.
    assign retire = (state_q == WRITE) && (!mem_we_q || bus.mem_ready);

    // On the accept edge the latches are still being loaded, so look through them.
    assign vec_sel  = accept ? bus.vec_in    : vec_q;
    assign base_sel = accept ? bus.base_addr : base_q;
    assign mask_sel = accept ? mask_in       : mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            vec_q       <= '0;
            base_q      <= '0;
            mask_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            if (accept) begin
                vec_q  <= bus.vec_in;
                base_q <= bus.base_addr;
                mask_q <= mask_in;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned, which would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = WRITE;
                    idx_d   = '0;
                end
            end
            WRITE: begin
                if (retire) begin
                    if (idx_q == LAST_IDX) state_d = DONE;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the state being entered.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        done_d      = 1'b0;
        busy_d      = (state_d != IDLE);
        if (state_d == WRITE) begin
            mem_we_d    = mask_sel[idx_d];
            mem_addr_d  = base_sel + ADDR_W'(idx_d);
            mem_wdata_d = vec_sel[{idx_d, 3'b000} +: 8];
        end
        if (state_d == DONE) begin
            done_d = 1'b1;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
